// File: rtl/class_vote_filter.sv
// Sliding-window majority-vote filter over per-sample class decisions.
// Circular buffer plus per-class occupancy counters; registered argmax one cycle after accept.
module class_vote_filter #(
    parameter int NUM_CLASSES = 10,
    parameter int MAX_WINDOW  = 16,
    parameter int TIE_MODE    = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [$clog2(MAX_WINDOW+1)-1:0]   cfg_window_i,
    input  logic                              flush_i,
    input  logic                              inp_valid_i,
    input  logic [$clog2(NUM_CLASSES)-1:0]    class_i,
    output logic                              out_valid_o,
    output logic [$clog2(NUM_CLASSES)-1:0]    out_class_o,
    output logic [$clog2(MAX_WINDOW+1)-1:0]   out_count_o,
    output logic                              out_full_o,
    output logic                              err_class_o
);
    localparam int CW = $clog2(NUM_CLASSES);
    localparam int NW = $clog2(MAX_WINDOW + 1);
    localparam int PW = (MAX_WINDOW > 1) ? $clog2(MAX_WINDOW) : 1;

    logic [CW-1:0] buf_q [MAX_WINDOW];
    logic [NW-1:0] cnt_q [NUM_CLASSES];
    logic [NW-1:0] fill_q;
    logic [NW-1:0] win_q;
    logic [PW-1:0] wr_ptr_q;
    logic          pend_q;
    logic [CW-1:0] newest_q;

    logic          bad_class;
    logic          accept;
    logic          full_now;
    logic [CW-1:0] evict;
    logic [NW-1:0] win_clamped;
    logic [CW-1:0] best_class;
    logic [NW-1:0] best_count;

    assign bad_class = 32'(class_i) >= NUM_CLASSES;
    assign accept    = inp_valid_i && !flush_i && !bad_class;
    assign full_now  = (fill_q == win_q);
    assign evict     = buf_q[wr_ptr_q];

    always_comb begin
        win_clamped = cfg_window_i;
        if (cfg_window_i == '0) begin
            win_clamped = NW'(1);
        end else if (32'(cfg_window_i) > MAX_WINDOW) begin
            win_clamped = NW'(MAX_WINDOW);
        end
    end

    // Strict '>' scan keeps the lowest tied index; TIE_MODE 1 then prefers the newest sample.
    always_comb begin
        best_class = '0;
        best_count = cnt_q[0];
        for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
            if (cnt_q[c] > best_count) begin
                best_class = CW'(c);
                best_count = cnt_q[c];
            end
        end
        if (TIE_MODE == 1 && cnt_q[newest_q] == best_count) begin
            best_class = newest_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MAX_WINDOW; i++) buf_q[i] <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
            fill_q      <= '0;
            win_q       <= NW'(MAX_WINDOW);
            wr_ptr_q    <= '0;
            pend_q      <= 1'b0;
            newest_q    <= '0;
            out_valid_o <= 1'b0;
            out_class_o <= '0;
            out_count_o <= '0;
            out_full_o  <= 1'b0;
            err_class_o <= 1'b0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < MAX_WINDOW; i++) buf_q[i] <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
            fill_q      <= '0;
            win_q       <= win_clamped;
            wr_ptr_q    <= '0;
            pend_q      <= 1'b0;
            out_valid_o <= 1'b0;
            out_class_o <= '0;
            out_count_o <= '0;
            out_full_o  <= 1'b0;
            err_class_o <= 1'b0;
        end else begin
            out_valid_o <= pend_q;
            err_class_o <= inp_valid_i && bad_class;
            pend_q      <= accept;
            if (pend_q) begin
                out_class_o <= best_class;
                out_count_o <= best_count;
                out_full_o  <= full_now;
            end
            if (accept) begin
                newest_q        <= class_i;
                buf_q[wr_ptr_q] <= class_i;
                if (full_now) begin
                    // Evicting the same class as the new one leaves its counter unchanged.
                    if (evict != class_i) begin
                        cnt_q[class_i] <= cnt_q[class_i] + NW'(1);
                        cnt_q[evict]   <= cnt_q[evict] - NW'(1);
                    end
                end else begin
                    cnt_q[class_i] <= cnt_q[class_i] + NW'(1);
                    fill_q         <= fill_q + NW'(1);
                end
                if (32'(wr_ptr_q) == 32'(win_q) - 1) begin
                    wr_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_class_vote_filter.sv
// Self-checking bench for class_vote_filter: one instance per tie policy, window-queue scoreboard.
module tb_class_vote_filter;
    localparam int NC = 10;
    localparam int MW = 16;
    localparam int CB = 4;
    localparam int WB = 5;

    typedef struct {
        logic [CB-1:0] cls;
        logic [WB-1:0] cnt;
        logic          full;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          inp_valid = 1'b0;
    logic [WB-1:0] cfg_window = '0;
    logic [CB-1:0] class_in = '0;

    logic          ov   [2];
    logic [CB-1:0] cls  [2];
    logic [WB-1:0] cnt  [2];
    logic          full [2];
    logic          err  [2];

    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   err_due = -1;
    int   w_m = MW;
    int   win_m[$];
    exp_t sb[2][$];

    always #5 clk = ~clk;

    class_vote_filter #(.NUM_CLASSES(NC), .MAX_WINDOW(MW), .TIE_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_window_i(cfg_window), .flush_i(flush),
        .inp_valid_i(inp_valid), .class_i(class_in), .out_valid_o(ov[0]),
        .out_class_o(cls[0]), .out_count_o(cnt[0]), .out_full_o(full[0]), .err_class_o(err[0])
    );

    class_vote_filter #(.NUM_CLASSES(NC), .MAX_WINDOW(MW), .TIE_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_window_i(cfg_window), .flush_i(flush),
        .inp_valid_i(inp_valid), .class_i(class_in), .out_valid_o(ov[1]),
        .out_class_o(cls[1]), .out_count_o(cnt[1]), .out_full_o(full[1]), .err_class_o(err[1])
    );

    // Reference: explicit window queue, recount from scratch on every accept.
    task automatic model_accept(input int c);
        int   counts[NC];
        int   b0;
        int   b1;
        exp_t e;
        win_m.push_back(c);
        if (win_m.size() > w_m) void'(win_m.pop_front());
        foreach (counts[k]) counts[k] = 0;
        foreach (win_m[i]) counts[win_m[i]]++;
        b0 = 0;
        for (int k = 1; k < NC; k++) if (counts[k] > counts[b0]) b0 = k;
        b1 = (counts[c] == counts[b0]) ? c : b0;
        e.cnt  = WB'(counts[b0]);
        e.full = (win_m.size() == w_m);
        e.due  = cyc + 2;
        e.cls  = CB'(b0);
        sb[0].push_back(e);
        e.cls  = CB'(b1);
        sb[1].push_back(e);
    endtask

    // One cycle: score outputs of the previous edge, then drive the next inputs.
    task automatic step(input logic v, input int c, input logic f, input int cfg);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
                e = sb[d].pop_front();
                asserts++;
                if (ov[d] !== 1'b1 || cls[d] !== e.cls || cnt[d] !== e.cnt || full[d] !== e.full) begin
                    fails++;
                    $display("FAIL sb_out dut%0d cyc %0d: got v=%b class=%0d count=%0d full=%b, want v=1 class=%0d count=%0d full=%b",
                             d, cyc, ov[d], cls[d], cnt[d], full[d], e.cls, e.cnt, e.full);
                end
            end else begin
                asserts++;
                if (ov[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL sb_spurious dut%0d cyc %0d: got out_valid=%b, want 0", d, cyc, ov[d]);
                end
            end
            asserts++;
            if (err[d] !== (cyc == err_due)) begin
                fails++;
                $display("FAIL sb_err dut%0d cyc %0d: got err_class=%b, want %b", d, cyc, err[d], (cyc == err_due));
            end
        end
        inp_valid  = v;
        class_in   = CB'(c);
        flush      = f;
        cfg_window = WB'(cfg);
        if (rst_n) begin
            if (f) begin
                w_m = (cfg == 0) ? 1 : ((cfg > MW) ? MW : cfg);
                win_m.delete();
                for (int d = 0; d < 2; d++)
                    while (sb[d].size() > 0 && sb[d][sb[d].size()-1].due > cyc) void'(sb[d].pop_back());
            end else if (v && c >= NC) begin
                err_due = cyc + 1;
            end else if (v) begin
                model_accept(c);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if ({ov[d], cls[d], cnt[d], full[d], err[d]} !== '0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: got v=%b class=%0d count=%0d full=%b err=%b, want all 0",
                         d, ov[d], cls[d], cnt[d], full[d], err[d]);
            end
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_fill;
        step(1'b1, 3, 1'b0, 0);
        step(1'b1, 3, 1'b0, 0);
        step(1'b1, 5, 1'b0, 0);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if (cls[d] !== 4'd3 || cnt[d] !== 5'd2 || full[d] !== 1'b0) begin
                fails++;
                $display("FAIL fill_final dut%0d: got (%0d,%0d,%b), want (3,2,0)", d, cls[d], cnt[d], full[d]);
            end
        end
    endtask

    task automatic test_eviction;
        int seq[6] = '{7, 7, 7, 2, 2, 2};
        step(1'b0, 0, 1'b1, 4);
        foreach (seq[i]) step(1'b1, seq[i], 1'b0, 9);
        idle(4);
        asserts++;
        if (cls[0] !== 4'd2 || cnt[0] !== 5'd3 || full[0] !== 1'b1) begin
            fails++;
            $display("FAIL evict_final: got (%0d,%0d,%b), want (2,3,1)", cls[0], cnt[0], full[0]);
        end
    endtask

    task automatic test_tie;
        int a[4] = '{6, 1, 6, 1};
        int b[4] = '{1, 6, 1, 6};
        step(1'b0, 0, 1'b1, 4);
        foreach (a[i]) step(1'b1, a[i], 1'b0, 0);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if (cls[d] !== 4'd1 || cnt[d] !== 5'd2) begin
                fails++;
                $display("FAIL tie_a dut%0d: got (%0d,%0d), want (1,2)", d, cls[d], cnt[d]);
            end
        end
        step(1'b0, 0, 1'b1, 4);
        foreach (b[i]) step(1'b1, b[i], 1'b0, 0);
        idle(4);
        asserts++;
        if (cls[0] !== 4'd1 || cnt[0] !== 5'd2) begin
            fails++;
            $display("FAIL tie_b_mode0: got (%0d,%0d), want (1,2)", cls[0], cnt[0]);
        end
        asserts++;
        if (cls[1] !== 4'd6 || cnt[1] !== 5'd2) begin
            fails++;
            $display("FAIL tie_b_mode1: got (%0d,%0d), want (6,2)", cls[1], cnt[1]);
        end
    endtask

    task automatic test_clamp_invalid;
        step(1'b0, 0, 1'b1, 0);
        step(1'b1, 4, 1'b0, 0);
        step(1'b1, 12, 1'b0, 0);
        step(1'b1, 9, 1'b0, 0);
        idle(4);
        asserts++;
        if (cls[0] !== 4'd9 || cnt[0] !== 5'd1 || full[0] !== 1'b1) begin
            fails++;
            $display("FAIL clamp_low_final: got (%0d,%0d,%b), want (9,1,1)", cls[0], cnt[0], full[0]);
        end
        step(1'b0, 0, 1'b1, 31);
        for (int i = 0; i < 17; i++) step(1'b1, (i * 7) % NC, 1'b0, 1);
        idle(4);
        asserts++;
        if (full[0] !== 1'b1) begin
            fails++;
            $display("FAIL clamp_high_full: got %b, want 1", full[0]);
        end
    endtask

    task automatic test_flush_collision;
        step(1'b0, 0, 1'b1, 4);
        step(1'b1, 8, 1'b0, 0);
        step(1'b1, 5, 1'b1, 4);
        idle(3);
        asserts++;
        if ({ov[0], cls[0], cnt[0], full[0]} !== '0) begin
            fails++;
            $display("FAIL flush_zero: got v=%b class=%0d count=%0d full=%b, want all 0", ov[0], cls[0], cnt[0], full[0]);
        end
        step(1'b1, 5, 1'b0, 0);
        idle(4);
        asserts++;
        if (cls[0] !== 4'd5 || cnt[0] !== 5'd1 || full[0] !== 1'b0) begin
            fails++;
            $display("FAIL flush_restart: got (%0d,%0d,%b), want (5,1,0)", cls[0], cnt[0], full[0]);
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 1, 1'b0, 0);
        step(1'b1, 2, 1'b0, 0);
        step(1'b1, 3, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if ({ov[d], cls[d], cnt[d], full[d], err[d]} !== '0) begin
                fails++;
                $display("FAIL async_reset dut%0d: got v=%b class=%0d count=%0d full=%b err=%b, want all 0",
                         d, ov[d], cls[d], cnt[d], full[d], err[d]);
            end
        end
        win_m.delete();
        sb[0].delete();
        sb[1].delete();
        err_due = -1;
        w_m = MW;
        step(1'b1, 4, 1'b0, 0);
        step(1'b1, 4, 1'b0, 0);
        step(1'b0, 0, 1'b0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b1, 2, 1'b0, 0);
        idle(4);
        asserts++;
        if (full[0] !== 1'b0 || cnt[0] !== 5'd15) begin
            fails++;
            $display("FAIL reset_window_15: got count=%0d full=%b, want 15,0", cnt[0], full[0]);
        end
        step(1'b1, 2, 1'b0, 0);
        step(1'b1, 2, 1'b0, 0);
        idle(4);
        asserts++;
        if (full[0] !== 1'b1 || cnt[0] !== 5'd16) begin
            fails++;
            $display("FAIL reset_window_16: got count=%0d full=%b, want 16,1", cnt[0], full[0]);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b0, 0, 1'b1, $urandom_range(1, MW));
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 24);
            if (r == 0) step(1'b1, $urandom_range(0, 11), 1'b1, $urandom_range(0, 31));
            else step(r < 21, $urandom_range(0, 11), 1'b0, $urandom_range(0, 31));
        end
        idle(4);
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if (sb[d].size() != 0) begin
                fails++;
                $display("FAIL sb_drain dut%0d: got %0d outputs outstanding, want 0", d, sb[d].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_eviction();
        test_tie();
        test_clamp_invalid();
        test_flush_collision();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
